counter_ud_sched: RTL

- Round-robin scheduler that shares one up/down counter (counter_ud, W-bit) among N requesters.
- Each requester submits a job: a start value and a target value. The scheduler loads the start value, sets the direction, lets the counter run until it reaches the target, then freezes it and signals completion.
- Sits between the requester agents and the counter's load_en/load/ud inputs. It monitors the counter's count output.

---
 rtl/counter_ud_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/counter_ud_sched.sv
// rtl/counter_ud_sched.sv - round-robin scheduler sharing one up/down counter among N requesters
// Optional abort support is built when CUD_SCHED_ABORT_EN is defined.
module counter_ud_sched #(
    parameter int N = 4,
    parameter int W = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   start_val,
    input  logic [N*W-1:0]   target_val,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic             busy,
    output logic [IW-1:0]    owner,
    input  logic [W-1:0]     cnt_count,
    output logic             cnt_load_en,
    output logic [W-1:0]     cnt_load,
    output logic             cnt_ud
`ifdef CUD_SCHED_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, owner_q, win_idx;
    logic          win_vld;
    logic [W-1:0]  s_q, t_q, win_s, win_t;
    logic          dir_q;
    logic          fin_abort_q, fin_abort_d;
    logic [N-1:0]  gnt_q, done_q;
    logic          hit, abort_in;

    assign hit = (cnt_count == t_q);

`ifdef CUD_SCHED_ABORT_EN
    assign abort_in = abort;
    assign aborted  = fin_abort_q && (state_q == FIN);
`else
    assign abort_in = 1'b0;
`endif

    // Completion wins over an abort arriving in the same RUN cycle.
    assign fin_abort_d = abort_in && ((state_q == LOAD) || ((state_q == RUN) && !hit));

    // Round-robin search starting just after the last granted index.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    assign win_s = start_val[win_idx*W +: W];
    assign win_t = target_val[win_idx*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(N - 1);
            owner_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            s_q         <= '0;
            t_q         <= '0;
            dir_q       <= 1'b1;
            fin_abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= '0;
            done_q  <= '0;
            if (state_q == IDLE && win_vld) begin
                ptr_q   <= win_idx;
                owner_q <= win_idx;
                s_q     <= win_s;
                t_q     <= win_t;
                dir_q   <= (win_t > win_s);
                gnt_q   <= ONE << win_idx;
            end
            if (state_d == FIN && state_q != FIN) begin
                fin_abort_q <= fin_abort_d;
                done_q      <= fin_abort_d ? '0 : (ONE << owner_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = LOAD;
            LOAD:    state_d = abort_in ? FIN : RUN;
            RUN:     if (hit || abort_in) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outside RUN the counter is always loaded, so it never drifts between jobs.
    always_comb begin
        cnt_load_en = 1'b1;
        cnt_load    = cnt_count;
        cnt_ud      = 1'b1;
        case (state_q)
            LOAD: begin
                cnt_ud = dir_q;
                if (!abort_in) cnt_load = s_q;
            end
            RUN: begin
                cnt_ud      = dir_q;
                cnt_load_en = hit || abort_in;
            end
            FIN: begin
                cnt_ud = dir_q;
                if (!fin_abort_q) cnt_load = t_q;
            end
            default: cnt_load_en = 1'b1;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;
    assign gnt   = gnt_q;
    assign done  = done_q;

endmodule
